// File: rtl/ocl_axil_bridge.sv
// ocl_axil_bridge
//   AXI4-Lite slave front-end for the Ising core register interface.
//   Single-beat reads and writes, independent AW/W channels, address window
//   [0, ADDR_SPAN). Writes become a one-cycle core_wr_en strobe; reads become
//   a core_rd_req pulse followed by a wait for core_rd_valid with a timeout.
//
//   Ports:
//     clk_main_a0, rst_main_n_sync        clock, synchronous active-low reset
//     aw*/w*/b*                           AXI-L write address/data/response
//     ar*/r*                              AXI-L read address/data
//     core_wr_en/addr/data/strb           core write strobe and payload
//     core_rd_req/addr                    core read request
//     core_rd_valid/data                  core read response
//
//   Optional: define OCL_BRIDGE_STATS_EN to add write/read/timeout counters
//   at ADDR_SPAN+0x0/+0x4/+0x8 (any write there clears all three).
//
//   state     | meaning
//   W_IDLE    | waiting for AW and/or W
//   W_HAVE_A  | address latched, waiting for W
//   W_HAVE_D  | data/strobes latched, waiting for AW
//   W_EXEC    | issue core write (if valid), compute bresp
//   W_RESP    | bvalid held until bready
//   R_IDLE    | waiting for AR
//   R_WAIT    | core read outstanding, timeout running
//   R_RESP    | rvalid held until rready
module ocl_axil_bridge #(
  parameter logic [31:0] ADDR_SPAN  = 32'h0000_1000,
  parameter int unsigned RD_TIMEOUT = 256,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n_sync,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  output logic        awready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        wready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  input  logic        bready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  output logic        arready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        rready,
  output logic        core_wr_en,
  output logic [31:0] core_wr_addr,
  output logic [31:0] core_wr_data,
  output logic [3:0]  core_wr_strb,
  output logic        core_rd_req,
  output logic [31:0] core_rd_addr,
  input  logic        core_rd_valid,
  input  logic [31:0] core_rd_data
);

  typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [15:0] TO_LOAD     = 16'(RD_TIMEOUT - 1);

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic        aw_hs, w_hs, ar_hs;
  logic [31:0] wr_addr_q, wr_data_q, rd_addr_q, rdata_q;
  logic [3:0]  wr_strb_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        rd_req_q, rd_timeout;
  logic [15:0] rd_cnt_q;
  logic        wr_in_range, ar_in_range;
  logic        wr_stat_hit, ar_stat_hit, rd_stat_q;
  logic [31:0] stat_rdata;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign ar_hs       = arvalid & arready;
  assign wr_in_range = wr_addr_q < ADDR_SPAN;
  assign ar_in_range = araddr < ADDR_SPAN;

  assign core_wr_addr = wr_addr_q;
  assign core_wr_data = wr_data_q;
  assign core_wr_strb = wr_strb_q;
  assign core_rd_req  = rd_req_q;
  assign core_rd_addr = rd_addr_q;
  assign bresp        = bresp_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;

`ifdef OCL_BRIDGE_STATS_EN
  logic [31:0] wr_off, ar_off;
  logic [31:0] cnt_wr, cnt_rd, cnt_to;
  logic [1:0]  rd_sel_q;

  // The !in_range term guarantees addr >= ADDR_SPAN, so the offsets never wrap.
  assign wr_off      = wr_addr_q - ADDR_SPAN;
  assign ar_off      = araddr - ADDR_SPAN;
  assign wr_stat_hit = !wr_in_range && (wr_off <= 32'd8);
  assign ar_stat_hit = !ar_in_range && (ar_off < 32'd12);

  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      rd_stat_q <= 1'b0;
      rd_sel_q  <= 2'd0;
      cnt_wr    <= '0;
      cnt_rd    <= '0;
      cnt_to    <= '0;
    end else begin
      if (ar_hs) begin
        rd_stat_q <= ar_stat_hit;
        rd_sel_q  <= ar_off[3:2];
      end
      if (w_state == W_EXEC && wr_stat_hit) begin
        cnt_wr <= '0;
        cnt_rd <= '0;
        cnt_to <= '0;
      end else begin
        if (bvalid && bready) cnt_wr <= cnt_wr + 32'd1;
        if (rvalid && rready) cnt_rd <= cnt_rd + 32'd1;
        if (rd_timeout)       cnt_to <= cnt_to + 32'd1;
      end
    end
  end

  always_comb begin
    stat_rdata = cnt_to;
    case (rd_sel_q)
      2'd0:    stat_rdata = cnt_wr;
      2'd1:    stat_rdata = cnt_rd;
      default: stat_rdata = cnt_to;
    endcase
  end
`else
  assign wr_stat_hit = 1'b0;
  assign ar_stat_hit = 1'b0;
  assign rd_stat_q   = 1'b0;
  assign stat_rdata  = '0;
`endif

  // Write FSM
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) w_state <= W_IDLE;
    else                  w_state <= w_next;
  end

  always_comb begin
    w_next     = w_state;
    awready    = 1'b0;
    wready     = 1'b0;
    core_wr_en = 1'b0;
    bvalid     = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) w_next = W_EXEC;
        else if (awvalid)      w_next = W_HAVE_A;
        else if (wvalid)       w_next = W_HAVE_D;
      end
      W_HAVE_A: begin
        wready = 1'b1;
        if (wvalid) w_next = W_EXEC;
      end
      W_HAVE_D: begin
        awready = 1'b1;
        if (awvalid) w_next = W_EXEC;
      end
      W_EXEC: begin
        core_wr_en = wr_in_range && (wr_strb_q != 4'd0);
        w_next     = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) wr_addr_q <= awaddr;
      if (w_hs) begin
        wr_data_q <= wdata;
        wr_strb_q <= wstrb;
      end
      if (w_state == W_EXEC)
        bresp_q <= (wr_in_range || wr_stat_hit) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read FSM
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) r_state <= R_IDLE;
    else                  r_state <= r_next;
  end

  always_comb begin
    r_next     = r_state;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rd_timeout = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = (ar_in_range || ar_stat_hit) ? R_WAIT : R_RESP;
      end
      R_WAIT: begin
        if (rd_stat_q || core_rd_valid) begin
          r_next = R_RESP;
        end else if (rd_cnt_q == 16'd0) begin
          rd_timeout = 1'b1;
          r_next     = R_RESP;
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Timeout is a down-counter loaded with RD_TIMEOUT-1 on AR; reaching zero
  // without valid means RD_TIMEOUT R_WAIT cycles have elapsed.
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_cnt_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rd_req_q <= ar_hs && ar_in_range;
      if (ar_hs) begin
        rd_addr_q <= araddr;
        rd_cnt_q  <= TO_LOAD;
        if (!ar_in_range && !ar_stat_hit) begin
          rdata_q <= ERR_DATA;
          rresp_q <= RESP_SLVERR;
        end
      end else if (r_state == R_WAIT) begin
        if (rd_stat_q) begin
          rdata_q <= stat_rdata;
          rresp_q <= RESP_OKAY;
        end else if (core_rd_valid) begin
          rdata_q <= core_rd_data;
          rresp_q <= RESP_OKAY;
        end else if (rd_timeout) begin
          rdata_q <= ERR_DATA;
          rresp_q <= RESP_SLVERR;
        end else begin
          rd_cnt_q <= rd_cnt_q - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ocl_axil_bridge.sv
module tb_ocl_axil_bridge;

  logic        clk_main_a0 = 1'b0;
  logic        rst_main_n_sync;
  logic        awvalid, wvalid, bready, arvalid, rready, core_rd_valid;
  logic [31:0] awaddr, wdata, araddr, core_rd_data;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, core_wr_en, core_rd_req;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, core_wr_addr, core_wr_data, core_rd_addr;
  logic [3:0]  core_wr_strb;

  always #5 clk_main_a0 = ~clk_main_a0;

  ocl_axil_bridge #(
    .ADDR_SPAN (32'h0000_1000),
    .RD_TIMEOUT(8),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk_main_a0    (clk_main_a0),
    .rst_main_n_sync(rst_main_n_sync),
    .awvalid        (awvalid),
    .awaddr         (awaddr),
    .awready        (awready),
    .wvalid         (wvalid),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .wready         (wready),
    .bvalid         (bvalid),
    .bresp          (bresp),
    .bready         (bready),
    .arvalid        (arvalid),
    .araddr         (araddr),
    .arready        (arready),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .rresp          (rresp),
    .rready         (rready),
    .core_wr_en     (core_wr_en),
    .core_wr_addr   (core_wr_addr),
    .core_wr_data   (core_wr_data),
    .core_wr_strb   (core_wr_strb),
    .core_rd_req    (core_rd_req),
    .core_rd_addr   (core_rd_addr),
    .core_rd_valid  (core_rd_valid),
    .core_rd_data   (core_rd_data)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lat;        // core_rd_valid this many cycles after core_rd_req; -1 = silent
    logic        exp_hit;    // core_wr_en / core_rd_req expected
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_cyc;    // rvalid cycle relative to AR handshake
  } vec_t;

  vec_t vecs[13];
  int   tests = 0;
  int   fails = 0;
  int   n_wr  = 0;
  int   n_rd  = 0;

  task automatic tick();
    @(negedge clk_main_a0);
    if (core_wr_en)  n_wr++;
    if (core_rd_req) n_rd++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready_valid"},
        64'({awready, wready, arready, bvalid, rvalid, core_wr_en, core_rd_req}),
        64'(7'b1110000));
    chk({tag, "_resp"}, 64'({bresp, rresp}), 64'(0));
    chk({tag, "_rdata"}, 64'(rdata), 64'(0));
    chk({tag, "_wr_bus"}, {core_wr_addr, core_wr_data}, 64'(0));
    chk({tag, "_rd_bus_strb"}, 64'({core_rd_addr, core_wr_strb}), 64'(0));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n0;
    int k;
    string nm;
    nm = $sformatf("v%0d", idx);
    if (v.is_wr) begin
      n0 = n_wr;
      awvalid = 1'b1; wvalid = 1'b1; awaddr = v.addr; wdata = v.data; wstrb = v.strb;
      bready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk({nm, "_wr_en"}, 64'(core_wr_en), 64'(v.exp_hit));
      if (v.exp_hit) begin
        chk({nm, "_wr_addr_data"}, {core_wr_addr, core_wr_data}, {v.addr, v.data});
        chk({nm, "_wr_strb"}, 64'(core_wr_strb), 64'(v.strb));
      end
      tick();
      chk({nm, "_bvalid"}, 64'(bvalid), 64'(1));
      chk({nm, "_bresp"}, 64'(bresp), 64'(v.exp_resp));
      tick();
      chk({nm, "_bclear"}, 64'(bvalid), 64'(0));
      chk({nm, "_wr_en_count"}, 64'(n_wr - n0), 64'(v.exp_hit));
    end else begin
      n0 = n_rd;
      arvalid = 1'b1; araddr = v.addr; rready = 1'b1;
      tick();
      k = 1;
      arvalid = 1'b0;
      chk({nm, "_rd_req"}, 64'(core_rd_req), 64'(v.exp_hit));
      if (v.exp_hit) chk({nm, "_rd_addr"}, 64'(core_rd_addr), 64'(v.addr));
      while (!rvalid && k < 400) begin
        core_rd_valid = (v.lat >= 0) && (k == v.lat + 1);
        core_rd_data  = v.data;
        tick();
        k++;
      end
      core_rd_valid = 1'b0;
      chk({nm, "_rvalid_cycle"}, 64'(k), 64'(v.exp_cyc));
      chk({nm, "_rdata"}, 64'(rdata), 64'(v.exp_rdata));
      chk({nm, "_rresp"}, 64'(rresp), 64'(v.exp_resp));
      tick();
      chk({nm, "_rclear"}, 64'(rvalid), 64'(0));
      chk({nm, "_rd_req_count"}, 64'(n_rd - n0), 64'(v.exp_hit));
    end
  endtask

  initial begin
    int n0;
    int k;
    int cnt;
    vec_t fresh;

    //          wr    addr          data          strb  lat hit resp   rdata         cyc
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 0, 1'b1, 2'b00, 32'h0,          0};
    vecs[1]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'h3, 0, 1'b1, 2'b00, 32'h0,          0};
    vecs[2]  = '{1'b1, 32'h0000_1000, 32'h1111_1111, 4'hF, 0, 1'b0, 2'b10, 32'h0,          0};
    vecs[3]  = '{1'b1, 32'h0000_0080, 32'h2222_2222, 4'h0, 0, 1'b0, 2'b00, 32'h0,          0};
    vecs[4]  = '{1'b1, 32'h0000_2000, 32'h3333_3333, 4'hF, 0, 1'b0, 2'b10, 32'h0,          0};
    vecs[5]  = '{1'b1, 32'h0000_0013, 32'h4444_5555, 4'h5, 0, 1'b1, 2'b00, 32'h0,          0};
    vecs[6]  = '{1'b0, 32'h0000_0040, 32'hA5A5_0001, 4'h0, 3, 1'b1, 2'b00, 32'hA5A5_0001, 5};
    vecs[7]  = '{1'b0, 32'h0000_0040, 32'h9999_9999, 4'h0, -1, 1'b1, 2'b10, 32'hDEAD_BEEF, 9};
    vecs[8]  = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, -1, 1'b0, 2'b10, 32'hDEAD_BEEF, 1};
    vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h1111_2222, 4'h0, 0, 1'b1, 2'b00, 32'h1111_2222, 2};
    vecs[10] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, -1, 1'b0, 2'b10, 32'hDEAD_BEEF, 1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, -1, 1'b0, 2'b10, 32'hDEAD_BEEF, 1};
    vecs[12] = '{1'b0, 32'h0000_0008, 32'h0000_7777, 4'h0, 7, 1'b1, 2'b00, 32'h0000_7777, 9};

    rst_main_n_sync = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    core_rd_valid = 1'b0; core_rd_data = '0;
    repeat (3) tick();
    chk_reset_state("por");
    rst_main_n_sync = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // W first, AW three cycles later; B held off for five cycles.
    n0 = n_wr;
    bready = 1'b0;
    wvalid = 1'b1; wdata = 32'h55AA_1234; wstrb = 4'hC;
    tick();
    wvalid = 1'b0;
    chk("split_ready_have_d", 64'({awready, wready}), 64'(2'b10));
    tick();
    tick();
    chk("split_no_early_wr", 64'(n_wr - n0), 64'(0));
    awvalid = 1'b1; awaddr = 32'h0000_0020;
    tick();
    awvalid = 1'b0;
    chk("split_wr_en", 64'(core_wr_en), 64'(1));
    chk("split_wr_addr_data", {core_wr_addr, core_wr_data}, {32'h0000_0020, 32'h55AA_1234});
    chk("split_wr_strb", 64'(core_wr_strb), 64'(4'hC));
    tick();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid && bresp == 2'b00) cnt++;
      tick();
    end
    chk("split_b_hold", 64'(cnt), 64'(5));
    chk("split_b_still", 64'(bvalid), 64'(1));
    bready = 1'b1;
    tick();
    chk("split_b_clear", 64'(bvalid), 64'(0));
    chk("split_wr_en_count", 64'(n_wr - n0), 64'(1));

    // Timeout with rready held low, then a late core response.
    rready = 1'b0;
    arvalid = 1'b1; araddr = 32'h0000_0040;
    tick();
    arvalid = 1'b0;
    k = 1;
    while (!rvalid && k < 400) begin
      tick();
      k++;
    end
    chk("to_rvalid_cycle", 64'(k), 64'(9));
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (rvalid && rdata == 32'hDEAD_BEEF && rresp == 2'b10) cnt++;
      tick();
    end
    chk("to_r_hold", 64'(cnt), 64'(3));
    rready = 1'b1;
    tick();
    chk("to_r_clear", 64'(rvalid), 64'(0));
    repeat (20) tick();
    core_rd_valid = 1'b1; core_rd_data = 32'h1234_5678;
    tick();
    core_rd_valid = 1'b0;
    tick();
    chk("late_valid_ignored", 64'({rvalid, arready}), 64'(2'b01));
    chk("late_valid_rdata", 64'(rdata), 64'(32'hDEAD_BEEF));

    // Concurrent write and read.
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h0000_0100; wdata = 32'h0F0F_0F0F; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h0000_0104; bready = 1'b1; rready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("conc_strobes", 64'({core_wr_en, core_rd_req}), 64'(2'b11));
    chk("conc_addrs", {core_wr_addr, core_rd_addr}, {32'h0000_0100, 32'h0000_0104});
    core_rd_valid = 1'b1; core_rd_data = 32'h600D_D00D;
    tick();
    core_rd_valid = 1'b0;
    chk("conc_b_r_valid", 64'({bvalid, rvalid}), 64'(2'b11));
    chk("conc_rdata", 64'({rresp, rdata}), 64'({2'b00, 32'h600D_D00D}));
    tick();
    chk("conc_clear", 64'({bvalid, rvalid}), 64'(0));

    // Reset while the read is in R_WAIT and the write is in W_HAVE_A.
    arvalid = 1'b1; araddr = 32'h0000_0040;
    tick();
    arvalid = 1'b0;
    awvalid = 1'b1; awaddr = 32'h0000_0030;
    tick();
    awvalid = 1'b0;
    chk("pre_reset_ready", 64'({awready, wready, arready}), 64'(3'b010));
    rst_main_n_sync = 1'b0;
    tick();
    chk_reset_state("midrst");
    rst_main_n_sync = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (rvalid || bvalid) cnt++;
      tick();
    end
    chk("midrst_no_resp", 64'(cnt), 64'(0));
    fresh = '{1'b1, 32'h0000_0044, 32'h0000_BEEF, 4'hF, 0, 1'b1, 2'b00, 32'h0, 0};
    run_vec(fresh, 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
